// File: rtl/bus_pkg.sv
// Shared types for the two-master slave-bus arbiter.
package bus_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        STROBE   = 4'b0010,
        COMPLETE = 4'b0100,
        ACK      = 4'b1000
    } arb_state_t;

    // Deasserted level of the active-low RD/WR strobes
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master request/ack signals plus the registered slave-bus control signals.
interface bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  M0_REQ;
    logic                  M0_WRITE;
    logic [ADDR_WIDTH-1:0] M0_ADDR;
    logic [DATA_WIDTH-1:0] M0_WDATA;
    logic [DATA_WIDTH-1:0] M0_RDATA;
    logic                  M0_ACK;
    logic                  M0_ERR;

    logic                  M1_REQ;
    logic                  M1_WRITE;
    logic [ADDR_WIDTH-1:0] M1_ADDR;
    logic [DATA_WIDTH-1:0] M1_WDATA;
    logic [DATA_WIDTH-1:0] M1_RDATA;
    logic                  M1_ACK;
    logic                  M1_ERR;

    logic                  BUS_CS;
    logic                  BUS_RD;
    logic                  BUS_WR;
    logic [ADDR_WIDTH-1:0] BUS_ADDR;

    modport master (
        output M0_REQ, M0_WRITE, M0_ADDR, M0_WDATA,
        input  M0_RDATA, M0_ACK, M0_ERR,
        output M1_REQ, M1_WRITE, M1_ADDR, M1_WDATA,
        input  M1_RDATA, M1_ACK, M1_ERR,
        input  BUS_CS, BUS_RD, BUS_WR, BUS_ADDR
    );

    modport slave (
        input  M0_REQ, M0_WRITE, M0_ADDR, M0_WDATA,
        output M0_RDATA, M0_ACK, M0_ERR,
        input  M1_REQ, M1_WRITE, M1_ADDR, M1_WDATA,
        output M1_RDATA, M1_ACK, M1_ERR,
        output BUS_CS, BUS_RD, BUS_WR, BUS_ADDR
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the master not served last wins.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic       LOAD,
    output logic       GRANT,
    output logic       VALID
);

    logic last_q;
    logic last_d;

    always_ff @(posedge CLK) begin
        if (RESET) last_q <= 1'b1;
        else       last_q <= last_d;
    end

    always_comb begin
        VALID  = |REQ;
        GRANT  = (REQ == 2'b11) ? ~last_q : REQ[1];
        last_d = last_q;
        if (LOAD && VALID) last_d = GRANT;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two masters onto the slave bus with a fixed strobe/complete/ack
// sequence, range-checking the address and returning read data per master.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 20,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            NUM_UNITS  = 524288,
    parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = '1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bus_arbiter_if.slave          bus,
    inout  wire  [DATA_WIDTH-1:0] BUS_DATA
);

    localparam int unsigned AW1 = ADDR_WIDTH + 1;

    arb_state_t state_q, state_d;

    logic                  grant, valid, load;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH+1:0] sel_off;
    logic                  sel_ok;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  win_q, win_d;
    logic                  err_q, err_d;

    logic                  cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [1:0]            ack_q, ack_d, errf_q, errf_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    rr_arbiter2 u_rr (
        .CLK   (CLK),
        .RESET (RESET),
        .REQ   ({bus.M1_REQ, bus.M0_REQ}),
        .LOAD  (load),
        .GRANT (grant),
        .VALID (valid)
    );

    // Offset from BASE_ADDR carries a borrow bit, so the upper bound never wraps
    always_comb begin
        sel_addr  = grant ? bus.M1_ADDR  : bus.M0_ADDR;
        sel_write = grant ? bus.M1_WRITE : bus.M0_WRITE;
        sel_wdata = grant ? bus.M1_WDATA : bus.M0_WDATA;
        sel_off   = {2'b00, sel_addr} - {2'b00, BASE_ADDR};
        sel_ok    = !sel_off[ADDR_WIDTH+1] && (sel_off[ADDR_WIDTH:0] < AW1'(NUM_UNITS));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            win_q      <= 1'b0;
            err_q      <= 1'b0;
            cs_q       <= 1'b0;
            rd_q       <= STROBE_OFF;
            wr_q       <= STROBE_OFF;
            oe_q       <= 1'b0;
            baddr_q    <= '0;
            ack_q      <= '0;
            errf_q     <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            win_q      <= win_d;
            err_q      <= err_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            baddr_q    <= baddr_d;
            ack_q      <= ack_d;
            errf_q     <= errf_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    load    = 1'b1;
                    state_d = sel_ok ? STROBE : ACK;
                end
            end
            STROBE:   state_d = COMPLETE;
            COMPLETE: state_d = ACK;
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        win_d   = win_q;
        err_d   = err_q;
        if (load) begin
            addr_d  = sel_addr;
            write_d = sel_write;
            wdata_d = sel_wdata;
            win_d   = grant;
            err_d   = !sel_ok;
        end
    end

    // Outputs are decoded from the state being entered so they appear registered
    always_comb begin
        cs_d       = 1'b0;
        rd_d       = STROBE_OFF;
        wr_d       = STROBE_OFF;
        oe_d       = 1'b0;
        baddr_d    = baddr_q;
        ack_d      = '0;
        errf_d     = '0;
        rdata_d[0] = rdata_q[0];
        rdata_d[1] = rdata_q[1];

        unique case (state_d)
            STROBE: begin
                cs_d    = 1'b1;
                baddr_d = addr_d;
                if (write_d) begin
                    wr_d = ~STROBE_OFF;
                    oe_d = 1'b1;
                end else begin
                    rd_d = ~STROBE_OFF;
                end
            end
            ACK: begin
                ack_d[win_d]  = 1'b1;
                errf_d[win_d] = err_d;
            end
            default: ;
        endcase

        if (state_q == COMPLETE && !write_q) rdata_d[win_q] = BUS_DATA;
        if (load && !sel_ok && !sel_write)   rdata_d[grant] = ERR_DATA;
    end

    assign BUS_DATA     = oe_q ? wdata_q : 'z;
    assign bus.BUS_CS   = cs_q;
    assign bus.BUS_RD   = rd_q;
    assign bus.BUS_WR   = wr_q;
    assign bus.BUS_ADDR = baddr_q;
    assign bus.M0_ACK   = ack_q[0];
    assign bus.M1_ACK   = ack_q[1];
    assign bus.M0_ERR   = errf_q[0];
    assign bus.M1_ERR   = errf_q[1];
    assign bus.M0_RDATA = rdata_q[0];
    assign bus.M1_RDATA = rdata_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one default-range instance and one offset-range instance.
module tb_bus_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    bus_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) if0 ();
    bus_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) if1 ();
    wire [7:0] bd0;
    wire [7:0] bd1;

    bus_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(if0), .BUS_DATA(bd0)
    );

    bus_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .BASE_ADDR(20'h80000), .NUM_UNITS(1024)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(if1), .BUS_DATA(bd1)
    );

    // Slave model for dut0: captures writes on the strobe edge, drives read data
    // through the following cycle; unwritten locations read as addr ^ 0x5A.
    logic [7:0]   mem [256];
    logic [255:0] vld;
    logic         s_en;
    logic [7:0]   s_val;
    logic         p_en;
    logic [7:0]   p_val;
    assign bd0 = p_en ? p_val : (s_en ? s_val : 8'bz);

    always @(posedge CLK) begin
        if (RESET) begin
            vld  <= '0;
            s_en <= 1'b0;
        end else begin
            s_en  <= if0.BUS_CS && !if0.BUS_RD;
            s_val <= vld[if0.BUS_ADDR[7:0]] ? mem[if0.BUS_ADDR[7:0]] : (if0.BUS_ADDR[7:0] ^ 8'h5A);
            if (if0.BUS_CS && !if0.BUS_WR) begin
                mem[if0.BUS_ADDR[7:0]] <= bd0;
                vld[if0.BUS_ADDR[7:0]] <= 1'b1;
            end
        end
    end

    // Slave model for dut1: read data is addr ^ 0xC3
    logic       s1_en;
    logic [7:0] s1_val;
    assign bd1 = s1_en ? s1_val : 8'bz;
    always @(posedge CLK) begin
        s1_en  <= if1.BUS_CS && !if1.BUS_RD;
        s1_val <= if1.BUS_ADDR[7:0] ^ 8'hC3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic probe0(input string tag);
        p_val = 8'h3C;
        p_en  = 1'b1;
        #1;
        chk(tag, bd0, 8'h3C);
        p_en  = 1'b0;
        #1;
    endtask

    initial begin
        p_en = 1'b0;
        p_val = 8'h00;
        RESET = 1'b1;
        if0.M0_REQ = 1'b1; if0.M0_WRITE = 1'b1; if0.M0_ADDR = 20'h00010; if0.M0_WDATA = 8'hA5;
        if0.M1_REQ = 1'b1; if0.M1_WRITE = 1'b0; if0.M1_ADDR = 20'h00030; if0.M1_WDATA = 8'h00;
        if1.M0_REQ = 1'b0; if1.M0_WRITE = 1'b0; if1.M0_ADDR = 20'h0;     if1.M0_WDATA = 8'h00;
        if1.M1_REQ = 1'b0; if1.M1_WRITE = 1'b0; if1.M1_ADDR = 20'h0;     if1.M1_WDATA = 8'h00;

        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_cs",   if0.BUS_CS, 1'b0);
            chk("rst_rd",   if0.BUS_RD, 1'b1);
            chk("rst_wr",   if0.BUS_WR, 1'b1);
            chk("rst_ack",  {if0.M0_ACK, if0.M1_ACK, if0.M0_ERR, if0.M1_ERR}, 4'b0000);
            chk("rst_addr", if0.BUS_ADDR, 20'h0);
            chk("rst_rdat", {if0.M0_RDATA, if0.M1_RDATA}, 16'h0000);
            probe0("rst_bus_released");
        end
        RESET = 1'b0;
        if0.M1_REQ = 1'b0;

        // M0 write 0x00010 <- 0xA5, first transaction after reset
        cyc();
        chk("wr_cs",   if0.BUS_CS, 1'b1);
        chk("wr_wr",   if0.BUS_WR, 1'b0);
        chk("wr_rd",   if0.BUS_RD, 1'b1);
        chk("wr_addr", if0.BUS_ADDR, 20'h00010);
        chk("wr_data", bd0, 8'hA5);
        chk("wr_ack1", if0.M0_ACK, 1'b0);
        cyc();
        chk("wr_cmp_cs", if0.BUS_CS, 1'b0);
        chk("wr_cmp_wr", if0.BUS_WR, 1'b1);
        chk("wr_cmp_addr", if0.BUS_ADDR, 20'h00010);
        chk("wr_ack2", if0.M0_ACK, 1'b0);
        probe0("wr_cmp_released");
        cyc();
        chk("wr_ack3", if0.M0_ACK, 1'b1);
        chk("wr_err3", if0.M0_ERR, 1'b0);
        chk("wr_ack3_m1", if0.M1_ACK, 1'b0);
        chk("wr_cs3",  if0.BUS_CS, 1'b0);
        if0.M0_REQ = 1'b0;

        // M0 read back 0x00010
        cyc();
        chk("idle_ack", if0.M0_ACK, 1'b0);
        if0.M0_REQ = 1'b1; if0.M0_WRITE = 1'b0;
        cyc();
        chk("rd_cs",   if0.BUS_CS, 1'b1);
        chk("rd_rd",   if0.BUS_RD, 1'b0);
        chk("rd_wr",   if0.BUS_WR, 1'b1);
        chk("rd_addr", if0.BUS_ADDR, 20'h00010);
        cyc();
        chk("rd_cmp_rd", {if0.BUS_CS, if0.BUS_RD}, 2'b01);
        cyc();
        chk("rd_ack",   if0.M0_ACK, 1'b1);
        chk("rd_err",   if0.M0_ERR, 1'b0);
        chk("rd_rdata", if0.M0_RDATA, 8'hA5);
        if0.M0_REQ = 1'b0;

        // M1 write 0x00030 <- 0x77 leaves M1 as last served
        cyc();
        if0.M1_REQ = 1'b1; if0.M1_WRITE = 1'b1; if0.M1_WDATA = 8'h77;
        cyc();
        chk("m1wr_strobe", {if0.BUS_CS, if0.BUS_RD, if0.BUS_WR}, 3'b110);
        chk("m1wr_addr", if0.BUS_ADDR, 20'h00030);
        chk("m1wr_data", bd0, 8'h77);
        cyc();
        cyc();
        chk("m1wr_ack", {if0.M1_ACK, if0.M0_ACK, if0.M1_ERR}, 3'b100);
        chk("m0_rdata_kept", if0.M0_RDATA, 8'hA5);
        if0.M1_REQ = 1'b0;

        // Both masters request reads continuously: M0, M1, M0, M1
        cyc();
        if0.M0_REQ = 1'b1; if0.M0_ADDR = 20'h00020;
        if0.M1_REQ = 1'b1; if0.M1_WRITE = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            chk("tie_cs",   if0.BUS_CS, (c % 4) == 1);
            chk("tie_ack0", if0.M0_ACK, (c % 8) == 3);
            chk("tie_ack1", if0.M1_ACK, (c % 8) == 7);
            if (c % 4 == 1) chk("tie_addr", if0.BUS_ADDR, ((c / 4) % 2 == 0) ? 20'h00020 : 20'h00030);
            if (c == 3 || c == 11) chk("tie_rdata0", if0.M0_RDATA, 8'h7A);
            if (c == 7 || c == 15) chk("tie_rdata1", if0.M1_RDATA, 8'h77);
        end
        if0.M0_REQ = 1'b0;
        if0.M1_REQ = 1'b0;

        // Out-of-range accesses on the offset instance
        cyc();
        if1.M1_REQ = 1'b1; if1.M1_ADDR = 20'h00000;
        cyc();
        chk("oor_cs",    if1.BUS_CS, 1'b0);
        chk("oor_ack",   if1.M1_ACK, 1'b1);
        chk("oor_err",   if1.M1_ERR, 1'b1);
        chk("oor_rdata", if1.M1_RDATA, 8'hFF);
        chk("oor_m0",    {if1.M0_ACK, if1.M0_ERR, if1.M0_RDATA}, 10'h000);
        if1.M1_REQ = 1'b0;
        cyc();
        chk("oor_ack_done", if1.M1_ACK, 1'b0);
        if1.M1_REQ = 1'b1; if1.M1_ADDR = 20'h803FF;
        cyc();
        chk("top_cs",   if1.BUS_CS, 1'b1);
        chk("top_addr", if1.BUS_ADDR, 20'h803FF);
        chk("top_ack1", if1.M1_ACK, 1'b0);
        cyc();
        cyc();
        chk("top_ack",   {if1.M1_ACK, if1.M1_ERR}, 2'b10);
        chk("top_rdata", if1.M1_RDATA, 8'h3C);
        if1.M1_REQ = 1'b0;
        cyc();
        if1.M1_REQ = 1'b1; if1.M1_ADDR = 20'h80400;
        cyc();
        chk("past_cs",    if1.BUS_CS, 1'b0);
        chk("past_ack",   {if1.M1_ACK, if1.M1_ERR}, 2'b11);
        chk("past_rdata", if1.M1_RDATA, 8'hFF);
        if1.M1_REQ = 1'b0;
        cyc();
        if1.M0_REQ = 1'b1; if1.M0_ADDR = 20'h7FFFF;
        cyc();
        chk("below_cs",    if1.BUS_CS, 1'b0);
        chk("below_ack",   {if1.M0_ACK, if1.M0_ERR}, 2'b11);
        chk("below_rdata", if1.M0_RDATA, 8'hFF);
        chk("below_m1",    if1.M1_RDATA, 8'hFF);
        if1.M0_REQ = 1'b0;

        // Reset during the COMPLETE cycle of an M0 read aborts it
        cyc();
        if0.M0_REQ = 1'b1; if0.M0_ADDR = 20'h00040;
        cyc();
        chk("abort_strobe", {if0.BUS_CS, if0.BUS_RD}, 2'b10);
        cyc();
        RESET = 1'b1;
        cyc();
        chk("abort_cs",    if0.BUS_CS, 1'b0);
        chk("abort_rd",    if0.BUS_RD, 1'b1);
        chk("abort_ack",   if0.M0_ACK, 1'b0);
        chk("abort_rdata", if0.M0_RDATA, 8'h00);
        chk("abort_addr",  if0.BUS_ADDR, 20'h0);
        probe0("abort_released");
        RESET = 1'b0;
        if0.M0_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_noack", {if0.M0_ACK, if0.M1_ACK, if0.BUS_CS}, 3'b000);
            chk("abort_rdata_hold", if0.M0_RDATA, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
